mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single byte-wide SimpleMmu port between two requesters: instruction fetch
//   (OpcodeBuffer) and data access (load/store path). Arbitrates, issues one byte
//   transaction at a time to the MMU, and returns the data to the granted requester.
//   Sits between the requesters and MMU port B.
//   Provides round-robin fairness and a watchdog against a hung MMU.
// PARAMETERS
//   FIXED_PRIORITY  0   1: fetch always wins a tie; 0: round-robin on ties
//   TIMEOUT         64  max cycles in ISSUE waiting for memBusy to rise; 0 disables watchdog
//   CNT_W           7   width of watchdog counter; must satisfy 2^CNT_W > TIMEOUT
// PORTS
//   clk              in   1   clock, all logic on rising edge
//   reset            in   1   synchronous, active-low reset
//   fetchAddr        in   32  fetch byte address (read only)
//   fetchRequest     in   1   fetch request, level
//   fetchBusy        out  1   fetch transaction pending/in flight
//   fetchData        out  8   last byte read for fetch
//   dataAddr         in   32  data byte address
//   dataRequest      in   1   data request, level
//   dataWriteEnable  in   1   1 = write dataIn, 0 = read
//   dataIn           in   8   write byte
//   dataBusy         out  1   data transaction pending/in flight
//   dataOut          out  8   last byte read for data
//   memAddr          out  32  to MMU address
//   memRequest       out  1   to MMU request
//   memWriteEnable   out  1   to MMU write enable
//   memDataIn        out  8   to MMU write data
//   memOut           in   8   from MMU read data
//   memBusy          in   1   from MMU busy
//   grantData        out  1   0 = fetch owns MMU, 1 = data owns (valid outside IDLE)
//   timeoutError     out  1   one-cycle pulse on watchdog abort
// BEHAVIOUR
//   Reset (reset==0 sampled): all outputs 0; state IDLE; lastGrant=data (fetch wins the first tie).
//     Reset mid-transaction abandons it; memRequest is 0 the next cycle; no data is returned.
//   States: IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: if a request is high, pick the winner and latch its addr/we/din into memAddr/memWriteEnable/memDataIn.
//     Fetch always has memWriteEnable=0.
//     Next cycle: ISSUE, memRequest=1, winner busy=1.
//     Tie: fetch wins if FIXED_PRIORITY==1 or lastGrant==data; otherwise data wins.
//     On grant, lastGrant := winner.
//   Loser with its request high: its busy=1 from the cycle after the request is first sampled.
//     It stays 1 until its own transaction completes.
//   ISSUE: hold memRequest=1 until memBusy sampled 1, then go to WAIT with memRequest=0.
//     Watchdog counts ISSUE cycles.
//     If the count reaches TIMEOUT (TIMEOUT!=0): abort to IDLE.
//     On abort: timeoutError=1 for 1 cycle, winner busy=0, winner data reg=8'hFF.
//   WAIT: when memBusy sampled 0 -> IDLE.
//     Same edge: a read loads memOut into fetchData/dataOut; a write leaves dataOut unchanged.
//     Winner busy=0 from that cycle.
//   Completion = falling edge of requester busy; its data reg is stable until its next completion.
//   Requester holds request/addr/we/din stable while busy=1; the arbiter uses the values latched at grant.
//   Level request: if still high after completion, busy is low exactly 1 cycle, then a new
//     transaction re-arbitrates (round-robin gives the other requester the MMU if it is waiting).
//   Requester drops request before grant: its pending busy clears next cycle; no MMU access.
//   memAddr/memWriteEnable/memDataIn hold their last values in IDLE.
//   Min latency: request high at cycle 0 -> memRequest at 1.
//     With MMU busy high cycles 2..N: data and busy low at N+2.
// TESTING
//   Fetch read addr 0 (MMU byte 0x3C), data idle -> fetchBusy 1..done, fetchData=0x3C, dataBusy stays 0.
//   Both request same cycle after reset -> fetch served first, then data; swap on next tie (RR).
//   FIXED_PRIORITY=1, both held high -> fetch served every transaction; data only when fetch drops request.
//   Data write 0xA5 to addr 8, then fetch read addr 8 -> memWriteEnable=1 once, fetchData=0xA5.
//   MMU model never raises memBusy, TIMEOUT=64 -> timeoutError pulse at 64 ISSUE cycles, fetchData=0xFF, IDLE.
//   reset low during WAIT -> next cycle all outputs 0; subsequent request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the byte-wide MMU port between instruction fetch and data access,
// one transaction at a time, with round-robin tie breaking and an ISSUE-phase watchdog.
module mem_port_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int TIMEOUT        = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetchAddr,
    input  logic        fetchRequest,
    output logic        fetchBusy,
    output logic [7:0]  fetchData,
    input  logic [31:0] dataAddr,
    input  logic        dataRequest,
    input  logic        dataWriteEnable,
    input  logic [7:0]  dataIn,
    output logic        dataBusy,
    output logic [7:0]  dataOut,
    output logic [31:0] memAddr,
    output logic        memRequest,
    output logic        memWriteEnable,
    output logic [7:0]  memDataIn,
    input  logic [7:0]  memOut,
    input  logic        memBusy,
    output logic        grantData,
    output logic        timeoutError
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    state_t           state_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             grant_d;
    // last_q == 1 means data was granted last, so fetch wins the next tie
    always_comb grant_d = dataRequest && (!fetchRequest || (!FIXED_PRIORITY && !last_q));
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            last_q         <= 1'b1;
            cnt_q          <= '0;
            fetchBusy      <= 1'b0;
            fetchData      <= '0;
            dataBusy       <= 1'b0;
            dataOut        <= '0;
            memAddr        <= '0;
            memRequest     <= 1'b0;
            memWriteEnable <= 1'b0;
            memDataIn      <= '0;
            grantData      <= 1'b0;
            timeoutError   <= 1'b0;
        end else begin
            timeoutError <= 1'b0;
            // a requester that does not own the port simply mirrors its request level
            if (state_q == S_IDLE || grantData) fetchBusy <= fetchRequest;
            if (state_q == S_IDLE || !grantData) dataBusy <= dataRequest;
            case (state_q)
                S_IDLE: begin
                    if (fetchRequest || dataRequest) begin
                        state_q        <= S_ISSUE;
                        memRequest     <= 1'b1;
                        grantData      <= grant_d;
                        last_q         <= grant_d;
                        cnt_q          <= '0;
                        memAddr        <= grant_d ? dataAddr : fetchAddr;
                        memWriteEnable <= grant_d && dataWriteEnable;
                        memDataIn      <= grant_d ? dataIn : 8'h00;
                    end
                end
                S_ISSUE: begin
                    if (memBusy) begin
                        state_q    <= S_WAIT;
                        memRequest <= 1'b0;
                    end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                        state_q      <= S_IDLE;
                        memRequest   <= 1'b0;
                        timeoutError <= 1'b1;
                        if (grantData) begin
                            dataBusy <= 1'b0;
                            dataOut  <= 8'hFF;
                        end else begin
                            fetchBusy <= 1'b0;
                            fetchData <= 8'hFF;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!memBusy) begin
                        state_q <= S_IDLE;
                        if (grantData) begin
                            dataBusy <= 1'b0;
                            if (!memWriteEnable) dataOut <= memOut;
                        end else begin
                            fetchBusy <= 1'b0;
                            fetchData <= memOut;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized requesters and MMU responder checked every cycle against a
// transaction-level reference of the arbitration rules, plus directed scenarios.
module tb_mem_port_arbiter;
    localparam bit FIXED = 1'b0;
    localparam int TMO   = 64;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetchAddr, dataAddr, memAddr;
    logic        fetchRequest, fetchBusy, dataRequest, dataWriteEnable, dataBusy;
    logic [7:0]  fetchData, dataIn, dataOut, memDataIn, memOut;
    logic        memRequest, memWriteEnable, memBusy, grantData, timeoutError;

    mem_port_arbiter #(.FIXED_PRIORITY(FIXED), .TIMEOUT(TMO), .CNT_W(7)) dut (
        .clk(clk), .reset(reset),
        .fetchAddr(fetchAddr), .fetchRequest(fetchRequest), .fetchBusy(fetchBusy), .fetchData(fetchData),
        .dataAddr(dataAddr), .dataRequest(dataRequest), .dataWriteEnable(dataWriteEnable), .dataIn(dataIn),
        .dataBusy(dataBusy), .dataOut(dataOut),
        .memAddr(memAddr), .memRequest(memRequest), .memWriteEnable(memWriteEnable), .memDataIn(memDataIn),
        .memOut(memOut), .memBusy(memBusy), .grantData(grantData), .timeoutError(timeoutError)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // reference state
    logic [7:0]  ref_mem [256];
    logic [7:0]  mmu_mem [256];
    int          owner = -1;
    bit          free_m = 1'b1, in_issue = 1'b0, last_d = 1'b1, din_known = 1'b1;
    int          iss = 0;
    logic [31:0] t_addr;
    bit          t_we;
    logic [7:0]  t_din;
    bit          e_fb, e_db, e_req, e_grant, e_we, e_tmo;
    logic [7:0]  e_fd, e_dd, e_din;
    logic [31:0] e_addr;

    // MMU responder and requester state
    int          mph = 0, mdly = 0, mlen = 0;
    bit          hang = 1'b0, m_raise, m_drop, m_we;
    logic [7:0]  m_a, m_din;
    bit          rnd = 1'b0, pf_b = 1'b0, pd_b = 1'b0, p_mreq = 1'b0;
    int          f_left = 0, d_left = 0, wr_cnt = 0, tmo_cnt = 0;
    bit          glog [$];

    task automatic mmu_go();
        memBusy = 1'b1;
        mlen    = int'($urandom_range(1, 3));
        mph     = 2;
        m_raise = 1'b1;
    endtask

    task automatic mmu_step();
        m_raise = 1'b0;
        m_drop  = 1'b0;
        memOut  = 8'($urandom);
        if (!reset) begin
            mph     = 0;
            memBusy = 1'b0;
        end else if (mph == 0) begin
            if (memRequest && !hang) begin
                m_a   = memAddr[7:0];
                m_we  = memWriteEnable;
                m_din = memDataIn;
                mdly  = int'($urandom_range(0, 2));
                if (mdly == 0) mmu_go();
                else mph = 1;
            end
        end else if (mph == 1) begin
            mdly--;
            if (mdly == 0) mmu_go();
        end else begin
            mlen--;
            if (mlen == 0) begin
                memBusy = 1'b0;
                mph     = 0;
                m_drop  = 1'b1;
                if (m_we) mmu_mem[m_a] = m_din;
                else memOut = mmu_mem[m_a];
            end
        end
    endtask

    // predicts the outputs visible after the coming edge from the inputs driven now
    task automatic predict();
        int fin;
        bit win;
        if (!reset) begin
            owner = -1; free_m = 1'b1; in_issue = 1'b0; iss = 0; last_d = 1'b1; din_known = 1'b1;
            {e_fb, e_db, e_req, e_grant, e_we, e_tmo} = '0;
            e_fd = '0; e_dd = '0; e_din = '0; e_addr = '0;
            return;
        end
        e_tmo = 1'b0;
        fin   = -1;
        if (!free_m) begin
            if (in_issue) begin
                if (m_raise) in_issue = 1'b0;
                else begin
                    iss++;
                    if (TMO != 0 && iss == TMO) begin
                        fin   = owner;
                        e_tmo = 1'b1;
                        if (owner == 0) e_fd = 8'hFF;
                        else e_dd = 8'hFF;
                    end
                end
            end else if (m_drop) begin
                fin = owner;
                if (t_we) ref_mem[t_addr[7:0]] = t_din;
                else if (owner == 0) e_fd = ref_mem[t_addr[7:0]];
                else e_dd = ref_mem[t_addr[7:0]];
            end
            if (fin >= 0) begin
                owner = -1; free_m = 1'b1; in_issue = 1'b0;
            end
            e_fb = (fin == 0) ? 1'b0 : (owner == 0) ? 1'b1 : fetchRequest;
            e_db = (fin == 1) ? 1'b0 : (owner == 1) ? 1'b1 : dataRequest;
        end else begin
            if (fetchRequest || dataRequest) begin
                win      = dataRequest && (!fetchRequest || (!FIXED && !last_d));
                owner    = int'(win);
                last_d   = win;
                free_m   = 1'b0;
                in_issue = 1'b1;
                iss      = 0;
                e_grant  = win;
                t_addr   = win ? dataAddr : fetchAddr;
                t_we     = win && dataWriteEnable;
                t_din    = dataIn;
                e_addr   = t_addr;
                e_we     = t_we;
                din_known = win;
                if (win) e_din = dataIn;
            end
            e_fb = fetchRequest;
            e_db = dataRequest;
        end
        e_req = (owner >= 0) && in_issue;
    endtask

    task automatic check();
        chk("fetchBusy", 32'(fetchBusy), 32'(e_fb));
        chk("dataBusy", 32'(dataBusy), 32'(e_db));
        chk("fetchData", 32'(fetchData), 32'(e_fd));
        chk("dataOut", 32'(dataOut), 32'(e_dd));
        chk("memRequest", 32'(memRequest), 32'(e_req));
        chk("grantData", 32'(grantData), 32'(e_grant));
        chk("memAddr", memAddr, e_addr);
        chk("memWriteEnable", 32'(memWriteEnable), 32'(e_we));
        if (din_known) chk("memDataIn", 32'(memDataIn), 32'(e_din));
        chk("timeoutError", 32'(timeoutError), 32'(e_tmo));
        if (memRequest && !p_mreq) begin
            glog.push_back(grantData);
            if (memWriteEnable) wr_cnt++;
        end
        p_mreq = memRequest;
        if (timeoutError) tmo_cnt++;
    endtask

    task automatic tick();
        mmu_step();
        predict();
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic clients();
        if (fetchRequest && pf_b && !fetchBusy) begin
            if (f_left > 0) f_left--;
            if (rnd ? $urandom_range(0, 1) == 0 : f_left == 0) fetchRequest = 1'b0;
            else if (rnd) fetchAddr = 32'($urandom_range(0, 15));
        end else if (!fetchRequest) begin
            if (f_left > 0 || (rnd && $urandom_range(0, 2) == 0)) begin
                fetchRequest = 1'b1;
                if (rnd) fetchAddr = 32'($urandom_range(0, 15));
            end
        end else if (rnd && owner != 0 && $urandom_range(0, 15) == 0) fetchRequest = 1'b0;
        pf_b = fetchBusy;
        if (dataRequest && pd_b && !dataBusy) begin
            if (d_left > 0) d_left--;
            if (rnd ? $urandom_range(0, 1) == 0 : d_left == 0) dataRequest = 1'b0;
            else if (rnd) begin
                dataAddr = 32'($urandom_range(0, 15)); dataWriteEnable = 1'($urandom); dataIn = 8'($urandom);
            end
        end else if (!dataRequest) begin
            if (d_left > 0 || (rnd && $urandom_range(0, 2) == 0)) begin
                dataRequest = 1'b1;
                if (rnd) begin
                    dataAddr = 32'($urandom_range(0, 15)); dataWriteEnable = 1'($urandom); dataIn = 8'($urandom);
                end
            end
        end else if (rnd && owner != 1 && $urandom_range(0, 15) == 0) dataRequest = 1'b0;
        pd_b = dataBusy;
    endtask

    task automatic wait_idle(input int max);
        bit ok = 1'b0;
        for (int n = 0; n < max && !ok; n++) begin
            clients();
            tick();
            ok = f_left == 0 && d_left == 0 && !fetchRequest && !dataRequest && free_m && !fetchBusy && !dataBusy;
        end
        chk("idle_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        fetchAddr = '0; fetchRequest = 1'b0; dataAddr = '0; dataRequest = 1'b0;
        dataWriteEnable = 1'b0; dataIn = '0; memOut = '0; memBusy = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            mmu_mem[i] = ref_mem[i];
        end
        ref_mem[0] = 8'h3C;
        mmu_mem[0] = 8'h3C;
        tick();
        tick();
        reset = 1'b1;
        // simultaneous requests straight after reset: fetch first, then alternate
        glog.delete();
        fetchAddr = 32'd1; dataAddr = 32'd2; f_left = 2; d_left = 2;
        wait_idle(100);
        chk("rr_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < glog.size() && i < 4; i++) chk("rr_order", 32'(glog[i]), 32'(i % 2));
        // lone fetch read of byte 0
        fetchAddr = 32'd0; f_left = 1;
        wait_idle(50);
        chk("fetch_rd0", 32'(fetchData), 32'h3C);
        // data write then fetch read of the same byte
        wr_cnt = 0;
        dataAddr = 32'd8; dataWriteEnable = 1'b1; dataIn = 8'hA5; d_left = 1;
        wait_idle(50);
        fetchAddr = 32'd8; f_left = 1;
        wait_idle(50);
        chk("write_once", 32'(wr_cnt), 32'd1);
        chk("fetch_rd8", 32'(fetchData), 32'hA5);
        // hung MMU
        hang = 1'b1; tmo_cnt = 0;
        fetchAddr = 32'd4; f_left = 1;
        wait_idle(200);
        hang = 1'b0;
        chk("tmo_pulses", 32'(tmo_cnt), 32'd1);
        chk("tmo_data", 32'(fetchData), 32'hFF);
        // reset while the MMU is busy
        fetchAddr = 32'd2; f_left = 1;
        for (int n = 0; n < 20 && !(mph == 2 && !memRequest && fetchBusy); n++) begin
            clients();
            tick();
        end
        chk("reach_wait", 32'(mph == 2 && !memRequest), 32'd1);
        reset = 1'b0; fetchRequest = 1'b0; f_left = 0;
        tick();
        reset = 1'b1;
        chk("rst_memreq", 32'(memRequest), 32'd0);
        chk("rst_fbusy", 32'(fetchBusy), 32'd0);
        chk("rst_fdata", 32'(fetchData), 32'd0);
        chk("rst_memaddr", memAddr, 32'd0);
        fetchAddr = 32'd0; f_left = 1;
        wait_idle(50);
        chk("post_rst_rd", 32'(fetchData), 32'h3C);
        // randomized traffic with occasional resets
        rnd = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            clients();
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0; fetchRequest = 1'b0; dataRequest = 1'b0;
            end
            tick();
            reset = 1'b1;
        end
        rnd = 1'b0;
        wait_idle(300);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
